clk_div_monitor: RTL and testbench
==================================

Name: clk_div_monitor

Overview:
- Receive-side checker for a divided clock. It samples a slow clock I_DIV_CLK in the I_REF_CLK domain and measures its high phase, low phase and period in reference cycles.
- It declares lock after a run of identical periods and flags a mismatch against the expected division ratio.
- It also flags a timeout when the input stops toggling.
- It sits beside the clock divider and is used for bring-up, self-test and clock-health monitoring.

Parameters:
- CNT_W, 8: phase counter width. A phase saturates at 2^CNT_W-1.
- LOCK_CNT, 4: number of consecutive identical periods needed to assert O_LOCK. Legal range 1..15.

Ports:
- RST_EN  in  1  asynchronous, active-low reset
- I_REF_CLK  in  1  reference clock; all logic is on its rising edge
- MEAS_EN  in  1  measurement enable; level-sensitive
- I_DIV_CLK  in  1  monitored clock; treated as asynchronous
- EXP_RATIO  in  8  expected period in I_REF_CLK cycles; 0 disables the mismatch check
- O_HIGH  out  CNT_W  last measured high-phase length
- O_LOW  out  CNT_W  last measured low-phase length
- O_PERIOD  out  CNT_W+1  last measured period, equal to O_HIGH+O_LOW
- O_VALID  out  1  one-cycle pulse when O_HIGH/O_LOW/O_PERIOD update
- O_LOCK  out  1  period stable
- O_MISMATCH  out  1  locked period differs from EXP_RATIO
- O_TIMEOUT  out  1  no edge within the saturation limit

Behaviour:
- Reset: RST_EN is asynchronous, active-low, on clock I_REF_CLK. During reset all outputs, counters, synchronizer flops and the match count are 0, and the FSM is in IDLE.
- Input path:
  - 2-flop synchronizer s1→s2, then a history flop s3.
  - rise = s2 & ~s3; fall = ~s2 & s3.
  - The synchronizer runs regardless of MEAS_EN.
- Phase counter `cnt`:
  - Loaded with 1 on any detected edge.
  - Otherwise increments by 1 each cycle, saturating at 2^CNT_W-1.
  - Result: a phase lasting H reference cycles at the synchronizer output yields exactly H.
- FSM states:
  - IDLE: entered whenever MEAS_EN=0, from any state, on the next clock. Clears O_LOCK, O_MISMATCH, O_TIMEOUT and the match count. O_HIGH, O_LOW and O_PERIOD hold their values. Leaves to SEEK when MEAS_EN=1.
  - SEEK: discards partial phases. On rise, go to HIGH (cnt=1).
  - HIGH: on fall, latch hi_tmp=cnt and go to LOW (cnt=1).
  - LOW: on rise, go to HIGH (cnt=1) and publish one measurement, registered on the same clock as the rise detect:
    - O_HIGH=hi_tmp, O_LOW=cnt, O_PERIOD=hi_tmp+cnt (zero-extended, no overflow).
    - O_VALID=1 for exactly 1 cycle.
    - O_TIMEOUT cleared.
- Latency: O_VALID asserts on the 4th I_REF_CLK rising edge after the I_DIV_CLK rising edge (2 sync stages, 1 detect stage, 1 output register).
- Lock logic, evaluated at each publish:
  - First publish after SEEK: match count=0, O_LOCK=0.
  - Later publishes: if new period == previous period, match count increments, saturating at LOCK_CNT. Otherwise match count=0 and O_LOCK drops on the same edge.
  - O_LOCK=1 when match count reaches LOCK_CNT. The first lock therefore comes at the (LOCK_CNT+1)-th publish.
- Mismatch: updated on each publish to O_LOCK_next & (EXP_RATIO!=0) & (period != EXP_RATIO). A change of EXP_RATIO takes effect at the next publish.
- Timeout:
  - In SEEK, HIGH or LOW, if cnt reaches 2^CNT_W-1 with no edge: O_TIMEOUT=1, O_LOCK=0, match count=0, go to SEEK.
  - Counter saturation in SEEK also counts toward the timeout.
  - O_TIMEOUT is sticky until the next publish or IDLE.
  - The phase that caused the timeout is never published.
- Simultaneous events:
  - An edge in the same cycle that cnt reaches saturation counts as an edge, not a timeout.
  - MEAS_EN deassert overrides any publish in that cycle: no O_VALID.
- Limits:
  - Phases shorter than 1 sampled cycle are unmeasurable. A clock equal to I_REF_CLK (divider bypass) shows as no toggling and produces a timeout.
  - Minimum measurable period is 2.
- Reset mid-operation: asynchronous clear to the reset values above. The first publish after release needs a full SEEK→HIGH→LOW→rise sequence.

Test Plan:
- Divide-by-4 (2 high/2 low), MEAS_EN=1, EXP_RATIO=4 → O_VALID every 4 cycles with O_HIGH=2, O_LOW=2, O_PERIOD=4; O_LOCK rises at the 5th O_VALID; O_MISMATCH=0.
- Divide-by-2 (1/1) and a 3-high/4-low waveform → O_PERIOD=2 (O_HIGH=1, O_LOW=1); then O_HIGH=3, O_LOW=4, O_PERIOD=7.
- Locked at 4, switch the source to 6 → O_LOCK=0 on the first O_VALID with period 6; O_LOCK=1 again after 4 further periods of 6.
- Locked at period 4 with EXP_RATIO=5 → O_MISMATCH=1 at the locking publish; set EXP_RATIO=0 → O_MISMATCH=0 at the next publish.
- Locked, then hold I_DIV_CLK low (CNT_W=8) → O_TIMEOUT=1 when cnt=255, O_LOCK=0, no O_VALID; restart the clock → O_TIMEOUT clears at the first publish.
- Assert RST_EN=0 mid-HIGH, and separately drop MEAS_EN for 1 cycle → all outputs 0 immediately on reset; on MEAS_EN drop, lock and flags clear and O_HIGH/O_LOW/O_PERIOD hold; the first O_VALID comes only after a complete new period.

Source files
------------

// File: rtl/clk_div_monitor.sv
`default_nettype none
// clk_div_monitor -- measures high/low/period of a divided clock in reference cycles and
// reports period lock, expected-ratio mismatch and loss-of-toggle timeout. Rev 1.0
module clk_div_monitor #(
  parameter int CNT_W    = 8,
  parameter int LOCK_CNT = 4
) (
  input  logic             RST_EN,
  input  logic             I_REF_CLK,
  input  logic             MEAS_EN,
  input  logic             I_DIV_CLK,
  input  logic [7:0]       EXP_RATIO,
  output logic [CNT_W-1:0] O_HIGH,
  output logic [CNT_W-1:0] O_LOW,
  output logic [CNT_W:0]   O_PERIOD,
  output logic             O_VALID,
  output logic             O_LOCK,
  output logic             O_MISMATCH,
  output logic             O_TIMEOUT
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEEK = 2'd1;
  localparam logic [1:0] HIGH = 2'd2;
  localparam logic [1:0] LOW  = 2'd3;

  localparam int               CMP_W    = (CNT_W + 1 > 8) ? CNT_W + 1 : 8;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [3:0]       LOCK_TGT = 4'(LOCK_CNT);

  logic             s1, s2, s3;
  logic             rise_d, fall_d, edge_d;
  logic [CNT_W-1:0] cnt, hi_tmp;
  logic [CNT_W:0]   period_new, prev_period;
  logic [CMP_W-1:0] period_cmp, exp_cmp;
  logic [3:0]       match_cnt, match_next;
  logic             have_prev;
  logic [1:0]       state, state_next;
  logic             sat, publish, latch_hi, timeout_ev, lock_next, mismatch_next;

  // Edge flags are registered, so the FSM acts one cycle after the history flop.
  always_ff @(posedge I_REF_CLK or negedge RST_EN) begin
    if (!RST_EN) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      s3     <= 1'b0;
      rise_d <= 1'b0;
      fall_d <= 1'b0;
    end else begin
      s1     <= I_DIV_CLK;
      s2     <= s1;
      s3     <= s2;
      rise_d <= s2 & ~s3;
      fall_d <= ~s2 & s3;
    end
  end

  assign edge_d = rise_d | fall_d;
  assign sat    = (cnt == CNT_MAX) && !edge_d;

  always_ff @(posedge I_REF_CLK or negedge RST_EN) begin
    if (!RST_EN)
      cnt <= '0;
    else if (edge_d)
      cnt <= CNT_ONE;
    else if (cnt != CNT_MAX)
      cnt <= cnt + CNT_ONE;
  end

  always_ff @(posedge I_REF_CLK or negedge RST_EN) begin
    if (!RST_EN)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (!MEAS_EN) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    state_next = SEEK;
        SEEK:    if (rise_d) state_next = HIGH;
        HIGH:    if (fall_d) state_next = LOW;  else if (sat) state_next = SEEK;
        LOW:     if (rise_d) state_next = HIGH; else if (sat) state_next = SEEK;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    publish    = MEAS_EN && (state == LOW) && rise_d;
    latch_hi   = MEAS_EN && (state == HIGH) && fall_d;
    timeout_ev = MEAS_EN && (state != IDLE) && sat;
    period_new = {1'b0, hi_tmp} + {1'b0, cnt};
    period_cmp = CMP_W'(period_new);
    exp_cmp    = CMP_W'(EXP_RATIO);
    if (!have_prev)
      match_next = 4'd0;
    else if (period_new == prev_period)
      match_next = (match_cnt == LOCK_TGT) ? match_cnt : match_cnt + 4'd1;
    else
      match_next = 4'd0;
    lock_next     = (match_next == LOCK_TGT);
    mismatch_next = lock_next && (|EXP_RATIO) && (period_cmp != exp_cmp);
  end

  // Deasserting MEAS_EN wins over a publish or timeout in the same cycle.
  always_ff @(posedge I_REF_CLK or negedge RST_EN) begin
    if (!RST_EN) begin
      hi_tmp      <= '0;
      prev_period <= '0;
      match_cnt   <= 4'd0;
      have_prev   <= 1'b0;
      O_HIGH      <= '0;
      O_LOW       <= '0;
      O_PERIOD    <= '0;
      O_VALID     <= 1'b0;
      O_LOCK      <= 1'b0;
      O_MISMATCH  <= 1'b0;
      O_TIMEOUT   <= 1'b0;
    end else begin
      O_VALID <= 1'b0;
      if (!MEAS_EN) begin
        match_cnt  <= 4'd0;
        have_prev  <= 1'b0;
        O_LOCK     <= 1'b0;
        O_MISMATCH <= 1'b0;
        O_TIMEOUT  <= 1'b0;
      end else begin
        if (latch_hi)
          hi_tmp <= cnt;
        if (publish) begin
          O_HIGH      <= hi_tmp;
          O_LOW       <= cnt;
          O_PERIOD    <= period_new;
          O_VALID     <= 1'b1;
          O_TIMEOUT   <= 1'b0;
          O_LOCK      <= lock_next;
          O_MISMATCH  <= mismatch_next;
          match_cnt   <= match_next;
          prev_period <= period_new;
          have_prev   <= 1'b1;
        end else if (timeout_ev) begin
          O_TIMEOUT <= 1'b1;
          O_LOCK    <= 1'b0;
          match_cnt <= 4'd0;
          have_prev <= 1'b0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_clk_div_monitor.sv
`default_nettype none
// Bench for clk_div_monitor: directed scenarios plus random waveforms, compared every
// cycle against a run-length model of the waveform with a fixed 4-cycle latency.
module tb_clk_div_monitor;
  localparam int CNT_W    = 8;
  localparam int LOCK_CNT = 4;
  localparam int SAT      = 1 << CNT_W;
  localparam int LAT      = 4;
  localparam int MAXT     = 16384;

  logic             RST_EN, I_REF_CLK, MEAS_EN, I_DIV_CLK;
  logic [7:0]       EXP_RATIO;
  logic [CNT_W-1:0] O_HIGH, O_LOW;
  logic [CNT_W:0]   O_PERIOD;
  logic             O_VALID, O_LOCK, O_MISMATCH, O_TIMEOUT;

  clk_div_monitor #(.CNT_W(CNT_W), .LOCK_CNT(LOCK_CNT)) dut (
    .RST_EN(RST_EN), .I_REF_CLK(I_REF_CLK), .MEAS_EN(MEAS_EN), .I_DIV_CLK(I_DIV_CLK),
    .EXP_RATIO(EXP_RATIO), .O_HIGH(O_HIGH), .O_LOW(O_LOW), .O_PERIOD(O_PERIOD),
    .O_VALID(O_VALID), .O_LOCK(O_LOCK), .O_MISMATCH(O_MISMATCH), .O_TIMEOUT(O_TIMEOUT)
  );

  initial I_REF_CLK = 1'b0;
  always #5 I_REF_CLK = ~I_REF_CLK;

  int n_chk, n_fail, t;
  // Expected register updates, indexed by the clock edge at which they appear.
  bit ev_pub[MAXT], ev_lock[MAXT], ev_tmo[MAXT], ev_clr[MAXT];
  int ev_hi[MAXT], ev_lo[MAXT];
  // Waveform model: run lengths of the driven level and the periods since the last seek.
  int prev_d, run_len, hi_len;
  bit meas, got_high;
  int pers[$];
  int m_hi, m_lo, m_per;
  bit m_valid, m_lock, m_mism, m_tmo;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s t=%0d observed=%0d expected=%0d", tag, t, obs, expv);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_high"}, 32'(O_HIGH), 0);
    chk({tag, "_low"}, 32'(O_LOW), 0);
    chk({tag, "_period"}, 32'(O_PERIOD), 0);
    chk({tag, "_valid"}, 32'(O_VALID), 0);
    chk({tag, "_lock"}, 32'(O_LOCK), 0);
    chk({tag, "_mismatch"}, 32'(O_MISMATCH), 0);
    chk({tag, "_timeout"}, 32'(O_TIMEOUT), 0);
  endtask

  task automatic model_publish(input int h, input int l);
    bit lk;
    pers.push_back(h + l);
    lk = 1'b0;
    if (pers.size() >= LOCK_CNT + 1) begin
      lk = 1'b1;
      for (int i = 1; i <= LOCK_CNT; i++)
        if (pers[pers.size() - 1 - i] != h + l) lk = 1'b0;
    end
    ev_pub[t + LAT]  = 1'b1;
    ev_hi[t + LAT]   = h;
    ev_lo[t + LAT]   = l;
    ev_lock[t + LAT] = lk;
  endtask

  // d is the level driven just after edge t.
  task automatic model_drive(input int d);
    if (d != prev_d) begin
      if (d == 0) begin
        if (meas) begin
          hi_len   = run_len;
          got_high = 1'b1;
        end
      end else begin
        if (meas && got_high && MEAS_EN) model_publish(hi_len, run_len);
        meas     = MEAS_EN;
        got_high = 1'b0;
      end
      prev_d  = d;
      run_len = 1;
    end else begin
      run_len++;
      if (MEAS_EN && run_len >= SAT) begin
        ev_tmo[t + LAT] = 1'b1;
        meas     = 1'b0;
        got_high = 1'b0;
        pers.delete();
      end
    end
  endtask

  task automatic model_reset();
    prev_d = 0; run_len = 0; hi_len = 0;
    meas = 1'b0; got_high = 1'b0;
    pers.delete();
    m_hi = 0; m_lo = 0; m_per = 0;
    m_valid = 1'b0; m_lock = 1'b0; m_mism = 1'b0; m_tmo = 1'b0;
    for (int i = 1; i <= 2 * LAT; i++) begin
      ev_pub[t + i] = 1'b0; ev_tmo[t + i] = 1'b0; ev_clr[t + i] = 1'b0;
    end
  endtask

  task automatic check_cycle();
    m_valid = 1'b0;
    if (ev_pub[t]) begin
      m_valid = 1'b1;
      m_hi    = ev_hi[t];
      m_lo    = ev_lo[t];
      m_per   = m_hi + m_lo;
      m_lock  = ev_lock[t];
      m_mism  = m_lock && (EXP_RATIO != 8'd0) && (m_per != int'(EXP_RATIO));
      m_tmo   = 1'b0;
    end
    if (ev_tmo[t]) begin
      m_tmo  = 1'b1;
      m_lock = 1'b0;
    end
    if (ev_clr[t]) begin
      m_lock = 1'b0; m_mism = 1'b0; m_tmo = 1'b0; m_valid = 1'b0;
    end
    chk("valid", 32'(O_VALID), 32'(m_valid));
    chk("high", 32'(O_HIGH), m_hi);
    chk("low", 32'(O_LOW), m_lo);
    chk("period", 32'(O_PERIOD), m_per);
    chk("lock", 32'(O_LOCK), 32'(m_lock));
    chk("mismatch", 32'(O_MISMATCH), 32'(m_mism));
    chk("timeout", 32'(O_TIMEOUT), 32'(m_tmo));
  endtask

  task automatic tick(input int d);
    @(posedge I_REF_CLK);
    t++;
    #1;
    check_cycle();
    I_DIV_CLK = (d != 0);
    model_drive(d);
  endtask

  task automatic hold(input int d, input int n);
    repeat (n) tick(d);
  endtask

  task automatic period(input int h, input int l);
    repeat (h) tick(1);
    repeat (l) tick(0);
  endtask

  task automatic set_en(input bit e);
    MEAS_EN = e;
    if (!e) begin
      meas = 1'b0;
      got_high = 1'b0;
      pers.delete();
      ev_clr[t + 1] = 1'b1;
    end
  endtask

  initial begin
    int h, l, reps;
    n_chk = 0; n_fail = 0; t = 0;
    RST_EN = 1'b0; MEAS_EN = 1'b1; I_DIV_CLK = 1'b0; EXP_RATIO = 8'd4;
    repeat (2) @(posedge I_REF_CLK);
    t += 2;
    #1;
    check_zero("reset");
    RST_EN = 1'b1;
    model_reset();
    model_drive(0);

    // Divide-by-4, then divide-by-2 and an asymmetric 3/4 waveform.
    repeat (8) period(2, 2);
    repeat (3) period(1, 1);
    repeat (2) period(3, 4);

    // Lock at 4, then move to 6 and relock.
    EXP_RATIO = 8'd0;
    repeat (6) period(2, 2);
    repeat (6) period(3, 3);

    // Locked at 4 against an expected 5, then disable the ratio check.
    EXP_RATIO = 8'd5;
    repeat (6) period(2, 2);
    EXP_RATIO = 8'd0;
    repeat (2) period(2, 2);

    // Stall the monitored clock low long enough to time out, then restart it.
    repeat (6) period(2, 2);
    hold(0, 300);
    chk("stall_timeout", 32'(O_TIMEOUT), 1);
    chk("stall_lock", 32'(O_LOCK), 0);
    repeat (3) period(2, 2);
    chk("restart_timeout", 32'(O_TIMEOUT), 0);

    // One-cycle MEAS_EN drop while the input sits low.
    repeat (6) period(2, 2);
    hold(0, 6);
    set_en(1'b0);
    tick(0);
    set_en(1'b1);
    chk("idle_lock", 32'(O_LOCK), 0);
    chk("idle_hold_high", 32'(O_HIGH), 2);
    chk("idle_hold_period", 32'(O_PERIOD), 4);
    hold(0, 6);
    repeat (3) period(2, 2);

    // Asynchronous reset in the middle of a high phase.
    hold(1, 6);
    #2;
    RST_EN = 1'b0;
    #1;
    check_zero("midreset");
    repeat (2) @(posedge I_REF_CLK);
    t += 2;
    #1;
    RST_EN = 1'b1;
    model_reset();
    model_drive(32'(I_DIV_CLK));
    hold(1, 4);
    repeat (4) period(3, 2);

    // Random waveforms with random expected ratios.
    for (int seg = 0; seg < 40; seg++) begin
      h    = $urandom_range(1, 6);
      l    = $urandom_range(1, 6);
      reps = $urandom_range(1, 7);
      case ($urandom_range(0, 2))
        0:       EXP_RATIO = 8'd0;
        1:       EXP_RATIO = 8'(h + l);
        default: EXP_RATIO = 8'($urandom_range(2, 12));
      endcase
      repeat (reps) period(h, l);
    end
    period(2, 2);
    hold(1, 8);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
